// File: rtl/sar_ctrl_pkg.sv
// Shared state encoding, width helper and timing defaults for the SAR scan controller.
package sar_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_SETTLE,
    S_CONV,
    S_WAIT,
    S_CAPT,
    S_DONE
  } scan_state_t;

  localparam int SETTLE_DEF  = 4;
  localparam int CNV_W_DEF   = 2;
  localparam int TIMEOUT_DEF = 64;

  // Never returns 0, so single-entry ranges still get a 1-bit field.
  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_ch_pick.sv
// Combinational finder for the lowest set mask bit at or above ptr.
module sar_ch_pick
  import sar_ctrl_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CH_W = ch_width(NCH)
) (
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W:0]   ptr,
  output logic            found,
  output logic [CH_W-1:0] index
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && ((CH_W+1)'(i) >= ptr)) begin
        found = 1'b1;
        index = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/sar_scan_ctrl.sv
// Multi-channel scan scheduler for the sar_logic core: settle, pulse cnvst, wait eoc, capture.
// Per channel: SETTLE + CNV_W + eoc delay + 3 cycles; results land in a bank and a pulse stream.
module sar_scan_ctrl
  import sar_ctrl_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 8,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int CNV_W   = CNV_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int CH_W   = ch_width(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            continuous,
  input  logic [NCH-1:0]  ch_mask,
  input  logic            err_clr,
  input  logic            eoc,
  input  logic [DW-1:0]   sar,
  input  logic [CH_W-1:0] rd_ch,
  output logic [CH_W-1:0] mux_sel,
  output logic            cnvst,
  output logic            busy,
  output logic            res_valid,
  output logic [CH_W-1:0] res_ch,
  output logic [DW-1:0]   res_data,
  output logic            scan_done,
  output logic            timeout_err,
  output logic [DW-1:0]   rd_data
);

  localparam int CNT_MAX = (SETTLE > CNV_W) ? ((SETTLE > TIMEOUT) ? SETTLE : TIMEOUT)
                                            : ((CNV_W > TIMEOUT) ? CNV_W : TIMEOUT);
  localparam int CNT_W = ch_width(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNV_END    = CNT_W'(CNV_W - 1);
  localparam logic [CNT_W-1:0] TO_END     = CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NCH - 1);
  localparam logic [CH_W:0]    NCH_P      = (CH_W+1)'(NCH);

  scan_state_t     state, state_n;
  logic [NCH-1:0]  mask;
  logic [CH_W:0]   ptr;
  logic [CH_W:0]   ptr_inc;
  logic [CNT_W-1:0] cnt;
  logic            eoc_d;
  logic            eoc_rise;
  logic            tmo;
  logic            pick_found;
  logic [CH_W-1:0] pick_idx;
  logic [DW-1:0]   bank [NCH];

  sar_ch_pick #(.NCH(NCH), .CH_W(CH_W)) u_pick (
    .mask  (mask),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign eoc_rise = eoc & ~eoc_d;
  assign ptr_inc  = {1'b0, mux_sel} + {{CH_W{1'b0}}, 1'b1};
  assign rd_data  = ({1'b0, rd_ch} < NCH_P) ? bank[rd_ch] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnvst   = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_n = (ch_mask == '0) ? S_DONE : S_PICK;
      S_PICK:   state_n = pick_found ? S_SETTLE : S_DONE;
      S_SETTLE: if (cnt == SETTLE_END) state_n = S_CONV;
      S_CONV: begin
        cnvst = 1'b1;
        if (cnt == CNV_END) state_n = S_WAIT;
      end
      S_WAIT: begin
        // An edge arriving on the last allowed cycle still counts as a conversion.
        if (eoc_rise) begin
          state_n = S_CAPT;
        end else if (cnt == TO_END) begin
          tmo     = 1'b1;
          state_n = S_PICK;
        end
      end
      S_CAPT:   state_n = (mux_sel == LAST_CH) ? S_DONE : S_PICK;
      S_DONE: begin
        if (continuous) state_n = (ch_mask == '0) ? S_DONE : S_PICK;
        else            state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask        <= '0;
      ptr         <= '0;
      cnt         <= '0;
      eoc_d       <= 1'b0;
      mux_sel     <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NCH; i++) bank[i] <= '0;
    end else begin
      eoc_d     <= eoc;
      res_valid <= 1'b0;
      scan_done <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask <= ch_mask;
            ptr  <= '0;
            busy <= 1'b1;
          end
        end
        S_PICK: begin
          if (pick_found) begin
            mux_sel <= pick_idx;
            cnt     <= '0;
          end
        end
        S_SETTLE: cnt <= (cnt == SETTLE_END) ? '0 : cnt + CNT_W'(1);
        S_CONV:   cnt <= (cnt == CNV_END) ? '0 : cnt + CNT_W'(1);
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (tmo) begin
            timeout_err <= 1'b1;
            ptr         <= ptr_inc;
          end
        end
        S_CAPT: begin
          bank[mux_sel] <= sar;
          res_data      <= sar;
          res_ch        <= mux_sel;
          res_valid     <= 1'b1;
          ptr           <= ptr_inc;
        end
        S_DONE: begin
          scan_done <= 1'b1;
          if (continuous) begin
            mask <= ch_mask;
            ptr  <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Self-checking bench for sar_scan_ctrl: vector table of scans plus hand-written timing sequences.
module tb_sar_scan_ctrl;

  localparam int NCH     = 4;
  localparam int DW      = 8;
  localparam int SETTLE  = 4;
  localparam int CNV_W   = 2;
  localparam int TIMEOUT = 64;
  localparam int EOC_DLY = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [3:0]    ch_mask = 4'b0000;
  logic          err_clr = 1'b0;
  logic          eoc;
  logic [7:0]    sar;
  logic [1:0]    rd_ch = 2'd0;
  logic [1:0]    mux_sel;
  logic          cnvst;
  logic          busy;
  logic          res_valid;
  logic [1:0]    res_ch;
  logic [7:0]    res_data;
  logic          scan_done;
  logic          timeout_err;
  logic [7:0]    rd_data;

  sar_scan_ctrl #(
    .NCH(NCH), .DW(DW), .SETTLE(SETTLE), .CNV_W(CNV_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .err_clr(err_clr), .eoc(eoc), .sar(sar), .rd_ch(rd_ch), .mux_sel(mux_sel),
    .cnvst(cnvst), .busy(busy), .res_valid(res_valid), .res_ch(res_ch),
    .res_data(res_data), .scan_done(scan_done), .timeout_err(timeout_err),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } res_t;

  typedef struct {
    logic [3:0]      mask;
    logic [3:0]      dead;
    logic [7:0]      salt;
    logic [3:0][7:0] exp_bank;
    logic            exp_err;
  } vec_t;

  res_t sbq[$];
  res_t obsq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int cnv_cyc = 0;
  int fall_cyc = 0;
  int to_lat = 0;
  logic prev_cnvst = 1'b0;
  logic prev_to = 1'b0;
  logic [3:0] dead_mask = 4'b0000;
  logic [7:0] salt = 8'h00;

  function automatic logic [7:0] chan_val(input logic [1:0] ch);
    logic [7:0] base;
    case (ch)
      2'd0: base = 8'hA5;
      2'd1: base = 8'h5A;
      2'd2: base = 8'h77;
      default: base = 8'h3C;
    endcase
    return base ^ salt;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: eoc rises EOC_DLY cycles after cnvst falls, unless the channel is dead.
  initial begin
    logic [1:0] ch_l;
    eoc = 1'b0;
    sar = 8'h00;
    forever begin
      @(negedge cnvst);
      ch_l = mux_sel;
      if (!rst && !dead_mask[ch_l]) begin
        repeat (EOC_DLY) @(posedge clk);
        #1;
        sar = chan_val(ch_l);
        eoc = 1'b1;
        @(posedge cnvst or posedge rst);
        eoc = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (res_valid) obsq.push_back('{ch: res_ch, data: res_data});
    if (scan_done) done_cnt++;
    if (cnvst) cnv_cyc++;
    if (prev_cnvst && !cnvst) fall_cyc = cyc;
    if (!prev_to && timeout_err) to_lat = cyc - fall_cyc;
    prev_cnvst = cnvst;
    prev_to = timeout_err;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!scan_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!scan_done) chk({nm, " scan_done wait"}, 0, 1);
  endtask

  task automatic drain(input string nm);
    res_t e, g;
    chk({nm, " result count"}, sbq.size(), obsq.size());
    while (sbq.size() > 0 && obsq.size() > 0) begin
      e = sbq.pop_front();
      g = obsq.pop_front();
      chk({nm, " res_ch"}, int'(g.ch), int'(e.ch));
      chk({nm, " res_data"}, int'(g.data), int'(e.data));
    end
    sbq.delete();
    obsq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [5];
    int d0, c0, r0, t1, t2, cm, n;

    vt[0] = '{mask: 4'b1011, dead: 4'b0000, salt: 8'h00,
              exp_bank: {8'h3C, 8'h00, 8'h5A, 8'hA5}, exp_err: 1'b0};
    vt[1] = '{mask: 4'b0110, dead: 4'b0010, salt: 8'h00,
              exp_bank: {8'h3C, 8'h77, 8'h5A, 8'hA5}, exp_err: 1'b1};
    vt[2] = '{mask: 4'b1111, dead: 4'b0000, salt: 8'hFF,
              exp_bank: {8'hC3, 8'h88, 8'hA5, 8'h5A}, exp_err: 1'b0};
    vt[3] = '{mask: 4'b1001, dead: 4'b1000, salt: 8'h0F,
              exp_bank: {8'hC3, 8'h88, 8'hA5, 8'hAA}, exp_err: 1'b1};
    vt[4] = '{mask: 4'b0100, dead: 4'b0000, salt: 8'hF0,
              exp_bank: {8'hC3, 8'h87, 8'hA5, 8'hAA}, exp_err: 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset cnvst", int'(cnvst), 0);
    chk("reset mux_sel", int'(mux_sel), 0);
    chk("reset res_valid", int'(res_valid), 0);
    chk("reset scan_done", int'(scan_done), 0);
    chk("reset timeout_err", int'(timeout_err), 0);
    chk("reset rd_data", int'(rd_data), 0);

    // Table of full scans; the bank accumulates across rows.
    for (int v = 0; v < 5; v++) begin
      ch_mask = vt[v].mask;
      dead_mask = vt[v].dead;
      salt = vt[v].salt;
      for (int c = 0; c < NCH; c++)
        if (vt[v].mask[c] && !vt[v].dead[c])
          sbq.push_back('{ch: 2'(c), data: chan_val(2'(c))});
      d0 = done_cnt;
      pulse_start();
      wait_done("vec", 2000);
      chk("vec busy at scan_done", int'(busy), 0);
      @(negedge clk);
      chk("vec scan_done count", done_cnt - d0, 1);
      drain("vec");
      chk("vec timeout_err", int'(timeout_err), int'(vt[v].exp_err));
      if (vt[v].exp_err) chk("vec timeout latency", to_lat, TIMEOUT);
      for (int c = 0; c < NCH; c++) begin
        rd_ch = 2'(c);
        #1;
        chk("vec bank", int'(rd_data), int'(vt[v].exp_bank[c]));
      end
      if (vt[v].exp_err) begin
        pulse_err_clr();
        @(negedge clk);
        chk("err_clr clears flag", int'(timeout_err), 0);
      end
    end
    dead_mask = 4'b0000;
    salt = 8'h00;

    // Empty mask: straight to DONE.
    ch_mask = 4'b0000;
    c0 = cnv_cyc;
    r0 = obsq.size();
    pulse_start();
    @(negedge clk);
    chk("empty scan_done early", int'(scan_done), 0);
    chk("empty busy", int'(busy), 1);
    @(negedge clk);
    chk("empty scan_done at +2", int'(scan_done), 1);
    chk("empty busy after", int'(busy), 0);
    @(negedge clk);
    chk("empty scan_done pulse width", int'(scan_done), 0);
    chk("empty cnvst cycles", cnv_cyc - c0, 0);
    chk("empty res_valid count", obsq.size() - r0, 0);

    // Continuous: mask change mid-scan takes effect on the next relatch.
    continuous = 1'b1;
    ch_mask = 4'b0001;
    sbq.push_back('{ch: 2'd0, data: chan_val(2'd0)});
    sbq.push_back('{ch: 2'd3, data: chan_val(2'd3)});
    d0 = done_cnt;
    pulse_start();
    repeat (3) @(negedge clk);
    ch_mask = 4'b1000;
    wait_done("cont first", 500);
    t1 = cyc;
    chk("cont busy between scans", int'(busy), 1);
    continuous = 1'b0;
    @(negedge clk);
    wait_done("cont second", 500);
    t2 = cyc;
    chk("cont scan spacing", t2 - t1, 1 + SETTLE + CNV_W + EOC_DLY + 1 + 1 + 1);
    chk("cont busy at end", int'(busy), 0);
    @(negedge clk);
    chk("cont scan_done count", done_cnt - d0, 2);
    drain("cont");

    // Reset in the middle of a conversion.
    ch_mask = 4'b1000;
    pulse_start();
    n = 0;
    while (!cnvst && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid cnvst reached", int'(cnvst), 1);
    chk("rstmid mux_sel before", int'(mux_sel), 3);
    #2 rst = 1'b1;
    #1;
    chk("rstmid cnvst async", int'(cnvst), 0);
    chk("rstmid busy async", int'(busy), 0);
    chk("rstmid mux_sel async", int'(mux_sel), 0);
    for (int c = 0; c < NCH; c++) begin
      rd_ch = 2'(c);
      #1;
      chk("rstmid bank cleared", int'(rd_data), 0);
    end
    sbq.delete();
    obsq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    ch_mask = 4'b0100;
    sbq.push_back('{ch: 2'd2, data: chan_val(2'd2)});
    pulse_start();
    wait_done("rstmid rescan", 500);
    @(negedge clk);
    drain("rstmid");
    rd_ch = 2'd2;
    #1;
    chk("rstmid bank ch2", int'(rd_data), 'h77);
    rd_ch = 2'd3;
    #1;
    chk("rstmid bank ch3", int'(rd_data), 0);

    // Settle and cnvst width timing; a start while busy is ignored.
    ch_mask = 4'b0010;
    sbq.push_back('{ch: 2'd1, data: chan_val(2'd1)});
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (mux_sel != 2'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cm = cyc;
    n = 0;
    while (!cnvst && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("timing settle", cyc - cm, SETTLE);
    n = 0;
    while (cnvst && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("timing cnvst width", n, CNV_W);
    ch_mask = 4'b1111;
    pulse_start();
    ch_mask = 4'b0010;
    wait_done("timing", 500);
    @(negedge clk);
    chk("timing scan_done count", done_cnt - d0, 1);
    drain("timing");
    repeat (3) @(negedge clk);
    chk("timing idle busy", int'(busy), 0);
    chk("timing mux_sel holds", int'(mux_sel), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_scan_ctrl.md
Name: sar_scan_ctrl

Overview:
- Multi-channel conversion scheduler for the 8-bit sar_logic converter core.
- Steps an analog input mux through the enabled channels.
- For each channel: waits a settle time, pulses cnvst, waits for eoc, then captures sar into a per-channel result bank and a result stream.
- Sits between the system/register interface and sar_logic.

Parameters:
NCH, 4, number of mux channels (2..8)
DW, 8, result width, matches sar_logic sar
SETTLE, 4, clk cycles from mux_sel change to cnvst assertion (1..255)
CNV_W, 2, cnvst high width in clk cycles (1..15)
TIMEOUT, 64, max clk cycles from cnvst fall to eoc rise

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begin a scan; ignored while busy
continuous  in  1  when high, a new scan starts automatically after scan_done
ch_mask  in  NCH  enabled channels; latched at scan start
err_clr  in  1  clears timeout_err
eoc  in  1  end-of-conversion from sar_logic
sar  in  DW  conversion result from sar_logic
rd_ch  in  clog2(NCH)  result bank read address
mux_sel  out  clog2(NCH)  analog mux select
cnvst  out  1  conversion start to sar_logic
busy  out  1  high from scan start until scan_done
res_valid  out  1  one-cycle pulse, new result on res_ch/res_data
res_ch  out  clog2(NCH)  channel of the current result
res_data  out  DW  captured sar value
scan_done  out  1  one-cycle pulse at end of scan
timeout_err  out  1  sticky, set on eoc timeout
rd_data  out  DW  combinational read of bank[rd_ch]

Behaviour:
- Reset (async, immediate): all outputs 0, mux_sel=0, bank entries 0, FSM=IDLE. cnvst drops immediately, including mid-conversion.
- eoc is registered once (eoc_d). A rising edge is eoc & ~eoc_d. Edges outside WAIT are ignored.
- FSM states: IDLE, PICK, SETTLE, CONV, WAIT, CAPT, DONE.
- IDLE:
  - start=1 -> latch mask=ch_mask, ptr=0, busy=1, go to PICK.
  - If mask==0 -> go to DONE directly.
- PICK:
  - Find the lowest set mask bit at index >= ptr.
  - Found -> mux_sel=index, settle counter=0, go to SETTLE.
  - None -> go to DONE.
- SETTLE: count SETTLE cycles, then go to CONV.
- CONV: cnvst=1 for exactly CNV_W cycles, then cnvst=0, timeout counter=0, go to WAIT.
- WAIT:
  - eoc rising edge -> go to CAPT.
  - TIMEOUT cycles with no edge -> set timeout_err, ptr=mux_sel+1, go to PICK. The channel is skipped: no res_valid, bank entry unchanged.
- CAPT (1 cycle):
  - bank[mux_sel]=sar, res_data=sar, res_ch=mux_sel, res_valid=1.
  - ptr=mux_sel+1. If ptr wraps past NCH-1 -> go to DONE, else go to PICK.
- DONE (1 cycle):
  - scan_done=1.
  - continuous=1 -> relatch ch_mask, ptr=0, stay busy, go to PICK (or DONE again if the mask is 0).
  - Else busy=0, go to IDLE.
- Latency per channel: SETTLE + CNV_W + (eoc delay) + 3 cycles.
- The earliest res_valid after start is SETTLE+CNV_W+eoc delay+4 cycles.
- start while busy is ignored. ch_mask changes mid-scan have no effect until the next latch.
- err_clr and a timeout in the same cycle: set wins.
- rd_data is combinational. A read of the channel being captured in the CAPT cycle returns the old value; the new value is visible the next cycle.
- mux_sel holds its last value in IDLE.

Decomposition:
- Package sar_ctrl_pkg holds:
  - state enum (IDLE..DONE)
  - CH_W = clog2(NCH) helper
  - default SETTLE / CNV_W / TIMEOUT constants
- Sub-module sar_ch_pick: combinational next-set-bit finder. Inputs mask and ptr; outputs found and index.
- The FSM, counters and result bank stay in sar_scan_ctrl.

Test Plan:
1. Single scan. ch_mask=4'b1011; eoc model rises 10 cycles after cnvst falls, sar=8'hA5/5A/3C per channel.
   -> res_valid on ch 0, 1, 3 in order with matching data; ch 2 bank stays 0; one scan_done; busy low after.
2. Empty mask. ch_mask=0, start pulse.
   -> scan_done 2 cycles after start; cnvst never high; no res_valid.
3. Timeout. ch_mask=4'b0110; eoc never rises for ch 1.
   -> timeout_err=1 TIMEOUT cycles after cnvst falls; ch 2 still converts and reports; err_clr clears the flag.
4. Continuous mode. continuous=1, ch_mask=4'b0001; change ch_mask to 4'b1000 mid-scan.
   -> the first scan reports ch 0 only; the next scan reports ch 3 only; the scan_done pulses are back-to-back scans with no IDLE gap.
5. Reset mid-conversion. Assert rst while cnvst=1 during CONV.
   -> cnvst, busy and mux_sel go to 0 without waiting for a clock edge; bank cleared; a new start after release works normally.
6. Timing check. SETTLE=4, CNV_W=2.
   -> cnvst rises exactly 4 cycles after the mux_sel update and stays high exactly 2 cycles; a start pulse during busy is ignored.
